mastermind_score_writer: RTL and testbench

Scores one MasterMind guess against the secret code and writes the resulting row into the video RAM. The row contains the guess symbols plus black/white peg markers, and `VGA_RAM_Controller` later renders it. The block sits between the button/game-control logic in the top level and the VIDEORAM write port: it takes over `ram_waddr`, `ram_wdata` and `ram_wen`, and reports the score to the segment display and LEDs. It runs entirely in the `CLK_PLL` domain.

---
 rtl/mastermind_score_writer.sv | 182 ++++++++++++++++++
 tb/tb_mastermind_score_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_score_writer.sv
// -----------------------------------------------------------------------------
// mastermind_score_writer
//
// Scores one MasterMind guess against the secret code, then writes the board
// row (guess symbols plus black/white peg markers) into the video RAM.
//
// Ports:
//   CLK        in   single clock (CLK_PLL domain)
//   RST_N      in   asynchronous active-low reset
//   START      in   one-cycle request to score a guess (honoured in IDLE only)
//   SECRET     in   secret code, position p at [p*SYM_W +: SYM_W]
//   GUESS      in   guess, packed like SECRET
//   ROW        in   board row to write
//   BUSY       out  high from START acceptance through the DONE cycle
//   DONE       out  one-cycle completion pulse
//   WIN        out  one-cycle pulse, DONE && BLACK == 4
//   BLACK      out  exact matches, held until the next DONE
//   WHITE      out  right-symbol wrong-position matches, held likewise
//   RAM_WADDR  out  video RAM write address {row, slot}
//   RAM_WDATA  out  video RAM write data {peg[2:0], symbol}
//   RAM_WEN    out  video RAM write enable
//
// Every output is a register fed from the FSM state, so each output event
// appears one cycle after the internal state that causes it. Internally the
// FSM enters EXACT right at the START edge; externally the fixed timeline is
// RAM_WEN in cycles 21..24 and DONE in cycle 25 after the START edge.
// -----------------------------------------------------------------------------
module mastermind_score_writer #(
    parameter int SYM_W = 3,
    parameter int ROW_W = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [4*SYM_W-1:0]   SECRET,
    input  logic [4*SYM_W-1:0]   GUESS,
    input  logic [ROW_W-1:0]     ROW,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 WIN,
    output logic [2:0]           BLACK,
    output logic [2:0]           WHITE,
    output logic [ROW_W+1:0]     RAM_WADDR,
    output logic [SYM_W+2:0]     RAM_WDATA,
    output logic                 RAM_WEN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXACT,
        S_MISS,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           step;        // EXACT/WRITE: slot in [1:0]; MISS: {i, j}
    logic [4*SYM_W-1:0]   secret_q, guess_q;
    logic [ROW_W-1:0]     row_q;
    logic [3:0]           gused, sused;
    logic [2:0]           black_cnt, white_cnt;

    logic                 accept;
    logic [1:0]           idx_i, idx_j;
    logic [SYM_W-1:0]     g_sym, s_sym;
    logic [2:0]           slot3, peg_lim;
    logic [2:0]           peg;

    // START is only seen in IDLE; the DONE state occupies the edge right
    // after the DONE pulse is registered, so a START on that edge is dropped.
    assign accept = START && (state == S_IDLE);

    // MISS walks guess slot i (outer) against secret slot j (inner); EXACT
    // and WRITE only need the low index.
    assign idx_i = (state == S_MISS) ? step[3:2] : step[1:0];
    assign idx_j = step[1:0];
    assign g_sym = guess_q[idx_i*SYM_W +: SYM_W];
    assign s_sym = secret_q[idx_j*SYM_W +: SYM_W];

    // Peg layout: black pegs first, then white, then empty. black+white <= 4
    // so the 3-bit sum cannot wrap.
    assign slot3   = {1'b0, idx_j};
    assign peg_lim = black_cnt + white_cnt;
    assign peg     = (slot3 < black_cnt) ? 3'd2 :
                     (slot3 < peg_lim)   ? 3'd1 : 3'd0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)          state_nxt = S_EXACT;
            S_EXACT: if (step == 4'd3)    state_nxt = S_MISS;
            S_MISS:  if (step == 4'd15)   state_nxt = S_WRITE;
            S_WRITE: if (step == 4'd3)    state_nxt = S_DONE;
            S_DONE:                       state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // Scoring datapath.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step      <= '0;
            secret_q  <= '0;
            guess_q   <= '0;
            row_q     <= '0;
            gused     <= '0;
            sused     <= '0;
            black_cnt <= '0;
            white_cnt <= '0;
        end else begin
            step <= (state != state_nxt) ? 4'd0 : step + 4'd1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        secret_q  <= SECRET;
                        guess_q   <= GUESS;
                        row_q     <= ROW;
                        gused     <= '0;
                        sused     <= '0;
                        black_cnt <= '0;
                        white_cnt <= '0;
                    end
                end
                S_EXACT: begin
                    if (g_sym == s_sym) begin
                        black_cnt    <= black_cnt + 3'd1;
                        gused[idx_i] <= 1'b1;
                        sused[idx_j] <= 1'b1;
                    end
                end
                S_MISS: begin
                    // Consuming the secret slot stops a duplicate guess symbol
                    // from scoring twice against it.
                    if (!gused[idx_i] && !sused[idx_j] && (g_sym == s_sym)) begin
                        white_cnt    <= white_cnt + 3'd1;
                        gused[idx_i] <= 1'b1;
                        sused[idx_j] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            WIN       <= 1'b0;
            BLACK     <= '0;
            WHITE     <= '0;
            RAM_WEN   <= 1'b0;
            RAM_WADDR <= '0;
            RAM_WDATA <= '0;
        end else begin
            BUSY    <= accept || (state != S_IDLE);
            DONE    <= (state == S_DONE);
            WIN     <= (state == S_DONE) && (black_cnt == 3'd4);
            RAM_WEN <= (state == S_WRITE);
            if (state == S_DONE) begin
                BLACK <= black_cnt;
                WHITE <= white_cnt;
            end
            // Address/data hold their last written value between writes.
            if (state == S_WRITE) begin
                RAM_WADDR <= {row_q, idx_j};
                RAM_WDATA <= {peg, g_sym};
            end
        end
    end

endmodule

// File: tb/tb_mastermind_score_writer.sv
// -----------------------------------------------------------------------------
// tb_mastermind_score_writer
//
// Directed bench for mastermind_score_writer at default parameters. Each
// scenario task starts one evaluation through run_eval, which records what the
// DUT did cycle by cycle (cycle c = interval after clock edge c, edge 0 being
// the START edge), then compares the record with hand-computed values.
// -----------------------------------------------------------------------------
module tb_mastermind_score_writer;

    localparam int SYM_W = 3;
    localparam int ROW_W = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [11:0] SECRET = '0;
    logic [11:0] GUESS = '0;
    logic [1:0]  ROW = '0;
    logic        BUSY, DONE, WIN, RAM_WEN;
    logic [2:0]  BLACK, WHITE;
    logic [3:0]  RAM_WADDR;
    logic [5:0]  RAM_WDATA;

    mastermind_score_writer #(.SYM_W(SYM_W), .ROW_W(ROW_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .SECRET    (SECRET),
        .GUESS     (GUESS),
        .ROW       (ROW),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .WIN       (WIN),
        .BLACK     (BLACK),
        .WHITE     (WHITE),
        .RAM_WADDR (RAM_WADDR),
        .RAM_WDATA (RAM_WDATA),
        .RAM_WEN   (RAM_WEN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Record of one evaluation.
    int          done_cnt, done_cyc, wen_cnt, wen_first;
    logic        win_at_done, busy_ok, win_ok, rst_zero_ok;
    logic [2:0]  black_at_done, white_at_done;
    logic [2:0]  black_c0, white_c0, black_c24, white_c24;
    logic [3:0]  waddr [4];
    logic [5:0]  wdata [4];

    function automatic logic [11:0] code(input int a, input int b, input int c, input int d);
        return {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    // Start one evaluation and observe cycles 0..27.
    // extra_start: edge at which a second START pulse (with guess g2) is sampled, -1 for none.
    // rst_at:      edge after which RST_N is pulled low for two cycles, -100 for none.
    task automatic run_eval(input logic [11:0] s, input logic [11:0] g, input logic [1:0] row,
                            input int extra_start, input logic [11:0] g2, input int rst_at);
        done_cnt = 0; done_cyc = -1; wen_cnt = 0; wen_first = -1;
        win_at_done = 1'bx; black_at_done = 'x; white_at_done = 'x;
        busy_ok = 1'b1; win_ok = 1'b1; rst_zero_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin waddr[k] = 'x; wdata[k] = 'x; end
        @(negedge CLK);
        SECRET = s; GUESS = g; ROW = row; START = 1'b1;
        @(posedge CLK);                            // edge 0
        for (int c = 0; c < 28; c++) begin
            if (c > 0) begin
                @(posedge CLK);                    // edge c
                if (c == rst_at) begin
                    #1 RST_N = 1'b0;
                    #1;
                    if (BUSY !== 1'b0 || DONE !== 1'b0 || WIN !== 1'b0 || RAM_WEN !== 1'b0 ||
                        BLACK !== 3'd0 || WHITE !== 3'd0 || RAM_WADDR !== 4'd0 || RAM_WDATA !== 6'd0)
                        rst_zero_ok = 1'b0;
                end
            end
            @(negedge CLK);
            if (BUSY !== ((c <= 25) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (c == 0)  begin black_c0 = BLACK;  white_c0 = WHITE;  end
            if (c == 24) begin black_c24 = BLACK; white_c24 = WHITE; end
            if (DONE === 1'b1) begin
                done_cnt++; done_cyc = c;
                win_at_done = WIN; black_at_done = BLACK; white_at_done = WHITE;
            end else if (WIN !== 1'b0) begin
                win_ok = 1'b0;
            end
            if (RAM_WEN === 1'b1) begin
                if (wen_cnt < 4) begin waddr[wen_cnt] = RAM_WADDR; wdata[wen_cnt] = RAM_WDATA; end
                if (wen_first < 0) wen_first = c;
                wen_cnt++;
            end
            // Scramble inputs after acceptance; they must not affect the result.
            START = 1'b0; SECRET = ~s; GUESS = ~g; ROW = ~row;
            if (c + 1 == extra_start) begin START = 1'b1; GUESS = g2; end
            if (c == rst_at + 2) RST_N = 1'b1;
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || WIN !== 1'b0 || RAM_WEN !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b win=%b wen=%b, want all 0", BUSY, DONE, WIN, RAM_WEN);
        end
        n_checks++;
        if (BLACK !== 3'd0 || WHITE !== 3'd0 || RAM_WADDR !== 4'd0 || RAM_WDATA !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_data: black=%0d white=%0d addr=%0h data=%0h, want all 0",
                     BLACK, WHITE, RAM_WADDR, RAM_WDATA);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_all_black();
        logic [5:0] exp_d [4];
        exp_d = '{6'h11, 6'h12, 6'h13, 6'h14};
        run_eval(code(1, 2, 3, 4), code(1, 2, 3, 4), 2'd0, -1, 12'd0, -100);
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 25) begin
            n_fail++; $display("FAIL all_black_done: count=%0d cycle=%0d, want 1 at 25", done_cnt, done_cyc);
        end
        n_checks++;
        if (win_at_done !== 1'b1 || black_at_done !== 3'd4 || white_at_done !== 3'd0) begin
            n_fail++;
            $display("FAIL all_black_score: win=%b black=%0d white=%0d, want 1/4/0", win_at_done, black_at_done, white_at_done);
        end
        n_checks++;
        if (wen_cnt !== 4 || wen_first !== 21) begin
            n_fail++; $display("FAIL all_black_wen: count=%0d first=%0d, want 4 from 21", wen_cnt, wen_first);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL all_black_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(k), exp_d[k]);
            end
        end
        n_checks++;
        if (!busy_ok || !win_ok) begin
            n_fail++; $display("FAIL all_black_busy: busy_ok=%b win_ok=%b, want 1/1", busy_ok, win_ok);
        end
    endtask

    task automatic test_all_white();
        logic [5:0] exp_d [4];
        exp_d = '{6'h0C, 6'h0B, 6'h0A, 6'h09};
        run_eval(code(1, 2, 3, 4), code(4, 3, 2, 1), 2'd1, -1, 12'd0, -100);
        n_checks++;
        if (done_cyc !== 25 || win_at_done !== 1'b0 || black_at_done !== 3'd0 || white_at_done !== 3'd4) begin
            n_fail++;
            $display("FAIL all_white_score: cycle=%0d win=%b black=%0d white=%0d, want 25/0/0/4",
                     done_cyc, win_at_done, black_at_done, white_at_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(4 + k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL all_white_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(4 + k), exp_d[k]);
            end
        end
    endtask

    task automatic test_duplicates();
        logic [5:0] exp_d [4];
        exp_d = '{6'h11, 6'h0A, 6'h09, 6'h00};
        run_eval(code(1, 1, 2, 2), code(1, 2, 1, 0), 2'd2, -1, 12'd0, -100);
        n_checks++;
        if (done_cyc !== 25 || win_at_done !== 1'b0 || black_at_done !== 3'd1 || white_at_done !== 3'd2) begin
            n_fail++;
            $display("FAIL dup_score: cycle=%0d win=%b black=%0d white=%0d, want 25/0/1/2",
                     done_cyc, win_at_done, black_at_done, white_at_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(8 + k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL dup_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(8 + k), exp_d[k]);
            end
        end
    endtask

    // Also pulses START on edge 25 (DONE cycle, BUSY still high): must be ignored.
    task automatic test_no_match();
        logic [5:0] exp_d [4];
        exp_d = '{6'h05, 6'h06, 6'h07, 6'h05};
        run_eval(code(0, 0, 0, 0), code(5, 6, 7, 5), 2'd3, 25, code(0, 0, 0, 0), -100);
        n_checks++;
        if (black_c0 !== 3'd1 || white_c0 !== 3'd2 || black_c24 !== 3'd1 || white_c24 !== 3'd2) begin
            n_fail++;
            $display("FAIL no_match_hold: c0=%0d/%0d c24=%0d/%0d, want 1/2 both", black_c0, white_c0, black_c24, white_c24);
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 25 || black_at_done !== 3'd0 || white_at_done !== 3'd0 || win_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_match_score: count=%0d cycle=%0d black=%0d white=%0d win=%b, want 1/25/0/0/0",
                     done_cnt, done_cyc, black_at_done, white_at_done, win_at_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(12 + k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL no_match_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(12 + k), exp_d[k]);
            end
        end
        n_checks++;
        if (!busy_ok || wen_cnt !== 4) begin
            n_fail++; $display("FAIL no_match_late_start: busy_ok=%b wen=%0d, want 1/4", busy_ok, wen_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        logic [5:0] exp_d [4];
        exp_d = '{6'h11, 6'h0B, 6'h0A, 6'h00};
        run_eval(code(1, 2, 3, 4), code(1, 3, 2, 0), 2'd0, 10, code(1, 2, 3, 4), -100);
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 25 || wen_cnt !== 4 || wen_first !== 21) begin
            n_fail++;
            $display("FAIL busy_start_timing: done=%0d@%0d wen=%0d@%0d, want 1@25 4@21", done_cnt, done_cyc, wen_cnt, wen_first);
        end
        n_checks++;
        if (black_at_done !== 3'd1 || white_at_done !== 3'd2 || win_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_score: black=%0d white=%0d win=%b, want 1/2/0", black_at_done, white_at_done, win_at_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL busy_start_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(k), exp_d[k]);
            end
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++; $display("FAIL busy_start_busy: busy profile wrong, want high 0..25 low 26..27");
        end
    endtask

    task automatic test_reset_mid_op();
        logic [5:0] exp_d [4];
        exp_d = '{6'h12, 6'h10, 6'h00, 6'h02};
        run_eval(code(1, 2, 3, 4), code(1, 2, 3, 4), 2'd2, -1, 12'd0, 22);
        n_checks++;
        if (!rst_zero_ok) begin
            n_fail++; $display("FAIL midreset_zero: outputs not all 0 right after reset, want 0");
        end
        n_checks++;
        if (wen_cnt !== 1 || done_cnt !== 0 || waddr[0] !== 4'd8 || wdata[0] !== 6'h11) begin
            n_fail++;
            $display("FAIL midreset_abort: wen=%0d done=%0d addr=%0h data=%0h, want 1/0/8/11",
                     wen_cnt, done_cnt, waddr[0], wdata[0]);
        end
        // Normal scoring after the abort.
        run_eval(code(2, 2, 2, 2), code(2, 0, 0, 2), 2'd1, -1, 12'd0, -100);
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 25 || black_at_done !== 3'd2 || white_at_done !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_after: done=%0d@%0d black=%0d white=%0d, want 1@25 2/0",
                     done_cnt, done_cyc, black_at_done, white_at_done);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (waddr[k] !== 4'(4 + k) || wdata[k] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL midreset_wr%0d: addr=%0h data=%0h, want addr=%0h data=%0h", k, waddr[k], wdata[k], 4'(4 + k), exp_d[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_black();
        test_all_white();
        test_duplicates();
        test_no_match();
        test_start_while_busy();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
